// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle RV32I control sequencer.
// Fetches one instruction at a time, steps it through decode, execute and
// writeback, and owns the program counter. Faults trap stickily until reset.
// Optional feature macro: PERF_COUNTERS_EN builds the cycle/retire counters;
// when undefined both counter ports are tied to 0.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        run,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  input  logic        isRT,
  input  logic        isIT,
  input  logic        isBT,
  input  logic        isJT,
  input  logic        isVI,
  input  logic        isJump,
  input  logic        enRegWrite,
  input  logic [31:0] immediateValue,
  input  logic [31:0] rs1Value,
  input  logic [31:0] aluResult,
  input  logic        aluBranchTaken,
  output logic        aluValid,
  output logic        regWrite,
  output logic [31:0] regWriteData,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trapCause,
  output logic [31:0] cycleCount,
  output logic [31:0] retireCount
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    WAIT_MEM  = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } stateT;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

  stateT       stateQ, stateD;
  logic [31:0] pcQ, instrQ, targetQ, targetD, waitCnt, pcPlus4;
  logic        trapQ;
  logic [1:0]  causeQ, causeD;
  logic        misaligned;
  logic        unusedRt;

  // R-type needs no special sequencing; it flows through the default path.
  assign unusedRt = isRT;

  assign pcPlus4    = pcQ + 32'd4;
  assign misaligned = targetQ[1:0] != 2'b00;

  assign imemAddr    = pcQ;
  assign pc          = pcQ;
  assign instruction = instrQ;
  assign state       = stateQ;
  assign trap        = trapQ;
  assign trapCause   = causeQ;

  // Next-PC selection, evaluated while in EXECUTE.
  always_comb begin
    targetD = pcPlus4;
    if (isJT)                        targetD = pcQ + immediateValue;
    else if (isJump && isIT)         targetD = (rs1Value + immediateValue) & ~32'd1;
    else if (isBT && aluBranchTaken) targetD = pcQ + immediateValue;
  end

  // Next-state, trap cause and per-state strobes.
  // imemReq is gated by rstN so it drops the moment reset is asserted even
  // while run is high in FETCH.
  always_comb begin
    stateD       = stateQ;
    causeD       = causeQ;
    imemReq      = 1'b0;
    aluValid     = 1'b0;
    regWrite     = 1'b0;
    regWriteData = '0;
    case (stateQ)
      FETCH: begin
        if (run) begin
          imemReq = rstN;
          stateD  = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        imemReq = rstN;
        if (imemReady) begin
          stateD = DECODE;
        end else if (MEM_TIMEOUT != 0 && waitCnt + 32'd1 == TIMEOUT) begin
          stateD = TRAP;
          causeD = 2'd3;
        end
      end
      DECODE: begin
        if (!isVI) begin
          stateD = TRAP;
          causeD = 2'd1;
        end else begin
          stateD = EXECUTE;
        end
      end
      EXECUTE: begin
        aluValid = 1'b1;
        stateD   = WRITEBACK;
      end
      WRITEBACK: begin
        if (misaligned) begin
          stateD = TRAP;
          causeD = 2'd2;
        end else begin
          regWrite     = enRegWrite;
          regWriteData = isJump ? pcPlus4 : aluResult;
          stateD       = FETCH;
        end
      end
      TRAP:    stateD = TRAP;
      default: stateD = FETCH;
    endcase
  end

  // State register, cause and sticky trap flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ <= FETCH;
      causeQ <= 2'd0;
      trapQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      causeQ <= causeD;
      if (stateD == TRAP) trapQ <= 1'b1;
    end
  end

  // Instruction register, memory wait counter, target and PC.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pcQ     <= RESET_PC;
      instrQ  <= NOP;
      targetQ <= RESET_PC;
      waitCnt <= '0;
    end else begin
      if (stateQ == WAIT_MEM) begin
        if (imemReady) begin
          instrQ  <= imemData;
          waitCnt <= '0;
        end else begin
          waitCnt <= waitCnt + 32'd1;
        end
      end
      if (stateQ == EXECUTE) targetQ <= targetD;
      if (stateQ == WRITEBACK && !misaligned) pcQ <= targetQ;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycQ, retQ;

  // Free-running cycle count (halts in TRAP) and retired-instruction count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycQ <= '0;
      retQ <= '0;
    end else begin
      if (stateQ != TRAP) cycQ <= cycQ + 32'd1;
      if (stateQ == WRITEBACK && !misaligned) retQ <= retQ + 32'd1;
    end
  end

  assign cycleCount  = cycQ;
  assign retireCount = retQ;
`else
  assign cycleCount  = '0;
  assign retireCount = '0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; decoder and ALU
// outputs are driven directly with hand-computed values.
module tb_instr_sequencer;
  logic        clk = 1'b0, rstN = 1'b0, run = 1'b0, imemReady = 1'b0;
  logic [31:0] imemData = '0, immediateValue = '0, rs1Value = '0, aluResult = '0;
  logic        isRT = 0, isIT = 0, isBT = 0, isJT = 0, isVI = 0, isJump = 0, enRegWrite = 0;
  logic        aluBranchTaken = 1'b0;
  logic        imemReq, aluValid, regWrite, trap;
  logic [31:0] imemAddr, instruction, regWriteData, pc, cycleCount, retireCount;
  logic [2:0]  state;
  logic [1:0]  trapCause;
  int          passCnt = 0, totalCnt = 0;

  instr_sequencer dut (
    .clk(clk), .rstN(rstN), .run(run), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemData(imemData), .instruction(instruction),
    .isRT(isRT), .isIT(isIT), .isBT(isBT), .isJT(isJT), .isVI(isVI), .isJump(isJump),
    .enRegWrite(enRegWrite), .immediateValue(immediateValue), .rs1Value(rs1Value),
    .aluResult(aluResult), .aluBranchTaken(aluBranchTaken), .aluValid(aluValid),
    .regWrite(regWrite), .regWriteData(regWriteData), .pc(pc), .state(state),
    .trap(trap), .trapCause(trapCause), .cycleCount(cycleCount), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setDec(input logic vi, input logic it, input logic bt, input logic jt,
                        input logic jmp, input logic en, input logic [31:0] imm);
    isVI = vi; isIT = it; isBT = bt; isJT = jt; isJump = jmp; enRegWrite = en;
    immediateValue = imm; isRT = 1'b0;
  endtask

  // Assert reset asynchronously, check reset values, release after one edge.
  task automatic doReset();
    rstN = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_imemReq", 32'(imemReq), 32'd0);
    check("rst_instr", instruction, 32'h13);
    check("rst_trap", {30'd0, trapCause}, 32'd0);
    check("rst_trapflag", 32'(trap), 32'd0);
    check("rst_strobes", {30'd0, aluValid, regWrite}, 32'd0);
    check("rst_wdata", regWriteData, 32'd0);
    check("rst_cycles", cycleCount, 32'd0);
    check("rst_retire", retireCount, 32'd0);
    tick();
    rstN = 1'b1;
  endtask

  // One instruction with imemReady in the first wait cycle; starts in FETCH.
  task automatic execInstr(input string tag, input logic [31:0] startPc, input logic expRw,
                           input logic chkWd, input logic [31:0] expWd, input logic [31:0] expPc);
    #1;
    check({tag, "_req"}, 32'(imemReq), 32'd1);
    check({tag, "_addr"}, imemAddr, startPc);
    tick();
    check({tag, "_wait"}, 32'(state), 32'd1);
    tick();
    check({tag, "_instr"}, instruction, imemData);
    tick();
    check({tag, "_aluValid"}, 32'(aluValid), 32'd1);
    tick();
    check({tag, "_wbState"}, 32'(state), 32'd4);
    check({tag, "_regWrite"}, 32'(regWrite), 32'(expRw));
    if (chkWd) check({tag, "_wdata"}, regWriteData, expWd);
    check({tag, "_pcHeld"}, pc, startPc);
    tick();
    check({tag, "_pc"}, pc, expPc);
    check({tag, "_fetch"}, 32'(state), 32'd0);
  endtask

  initial begin
    tick(); tick();
    doReset();
    run = 1'b1; imemReady = 1'b1;

    // ADDI x1,x2,100
    imemData = 32'h0641_0093; aluResult = 32'h64;
    setDec(1, 1, 0, 0, 0, 1, 32'd100);
    execInstr("addi0", 32'h0, 1, 1, 32'h64, 32'h4);
    execInstr("addi1", 32'h4, 1, 1, 32'h64, 32'h8);
    execInstr("addi2", 32'h8, 1, 1, 32'h64, 32'hC);
`ifdef PERF_COUNTERS_EN
    check("perf_retire3", retireCount, 32'd3);
    check("perf_cycles15", cycleCount, 32'd15);
`else
    check("perf_off_retire", retireCount, 32'd0);
    check("perf_off_cycles", cycleCount, 32'd0);
`endif
    execInstr("addi3", 32'hC, 1, 1, 32'h64, 32'h10);

    // BEQ imm=8, taken then not taken
    imemData = 32'h0000_0463; aluResult = 32'h1; aluBranchTaken = 1'b1;
    setDec(1, 0, 1, 0, 0, 0, 32'd8);
    execInstr("beqT", 32'h10, 0, 0, 32'h0, 32'h18);
    aluBranchTaken = 1'b0;
    execInstr("beqN", 32'h18, 0, 0, 32'h0, 32'h1C);

    imemData = 32'h0641_0093; aluResult = 32'h64;
    setDec(1, 1, 0, 0, 0, 1, 32'd100);
    execInstr("addi4", 32'h1C, 1, 1, 32'h64, 32'h20);

    // JAL x1,1024 then JALR rs1=0x101 imm=0x10
    imemData = 32'h4000_00EF; aluResult = 32'hDEAD;
    setDec(1, 0, 0, 1, 1, 1, 32'h400);
    execInstr("jal", 32'h20, 1, 1, 32'h24, 32'h420);
    imemData = 32'h0100_80E7; rs1Value = 32'h101;
    setDec(1, 1, 0, 0, 1, 1, 32'h10);
    execInstr("jalr", 32'h420, 1, 1, 32'h424, 32'h110);

    // Misaligned jump target 0x112
    imemData = 32'h0020_00EF;
    setDec(1, 0, 0, 1, 1, 1, 32'h2);
    #1; tick(); tick(); tick(); tick();
    check("mis_wbState", 32'(state), 32'd4);
    check("mis_regWrite", 32'(regWrite), 32'd0);
    tick();
    check("mis_state", 32'(state), 32'd5);
    check("mis_trap", 32'(trap), 32'd1);
    check("mis_cause", 32'(trapCause), 32'd2);
    check("mis_pc", pc, 32'h110);
    tick(); tick();
    check("mis_pcFrozen", pc, 32'h110);
    check("mis_noReq", 32'(imemReq), 32'd0);

    // Illegal instruction at pc=4
    doReset();
    imemData = 32'h0641_0093; aluResult = 32'h64;
    setDec(1, 1, 0, 0, 0, 1, 32'd100);
    execInstr("addi5", 32'h0, 1, 1, 32'h64, 32'h4);
    imemData = 32'hFFFF_FFFF;
    setDec(0, 0, 0, 0, 0, 0, 32'h0);
    #1; tick(); tick();
    check("ill_instr", instruction, 32'hFFFF_FFFF);
    tick();
    check("ill_state", 32'(state), 32'd5);
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trapCause), 32'd1);
    check("ill_pc", pc, 32'h4);
    tick(); tick(); tick();
    check("ill_pcFrozen", pc, 32'h4);
    check("ill_instrFrozen", instruction, 32'hFFFF_FFFF);
    check("ill_strobes", {29'd0, imemReq, aluValid, regWrite}, 32'd0);

    // Fetch timeout: 15 wait cycles without imemReady
    doReset();
    imemReady = 1'b0;
    setDec(1, 1, 0, 0, 0, 1, 32'd100);
    tick();
    check("to_wait", 32'(state), 32'd1);
    repeat (14) tick();
    check("to_stillWait", 32'(state), 32'd1);
    check("to_req", 32'(imemReq), 32'd1);
    tick();
    check("to_state", 32'(state), 32'd5);
    check("to_cause", 32'(trapCause), 32'd3);
    check("to_trap", 32'(trap), 32'd1);
    check("to_noReq", 32'(imemReq), 32'd0);
    imemReady = 1'b1;
    tick();
    check("to_sticky", 32'(state), 32'd5);

    // Reset pulsed mid-WAIT_MEM, then refetch from RESET_PC
    doReset();
    imemReady = 1'b0;
    tick(); tick();
    check("mw_req", 32'(imemReq), 32'd1);
    doReset();
    imemReady = 1'b1; imemData = 32'h0641_0093;
    execInstr("addi6", 32'h0, 1, 1, 32'h64, 32'h4);

    // run low parks the core in FETCH
    run = 1'b0;
    tick(); tick(); tick();
    check("park_state", 32'(state), 32'd0);
    check("park_req", 32'(imemReq), 32'd0);
    check("park_pc", pc, 32'h4);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
